// File: rtl/conf_dev_regs_pkg.sv
// Shared definitions for the per-device configuration register bank:
// register offsets, CTRL bit positions, unlock key, slot base addresses, FSM states.
package conf_dev_regs_pkg;

    localparam logic [15:0] CDR_ID   = 16'd0;
    localparam logic [15:0] CDR_CTRL = 16'd1;
    localparam logic [15:0] CDR_KEY  = 16'd2;
    localparam logic [15:0] CDR_CFG0 = 16'd3;

    localparam int CTRL_COMMIT = 0;
    localparam int CTRL_REVERT = 1;
    localparam int CTRL_CLRERR = 2;

    localparam logic [15:0] UNLOCK_KEY = 16'hC0F1;

    localparam logic [15:0] DEV0_ADDR_BASE = 16'h0100;
    localparam logic [15:0] DEV1_ADDR_BASE = 16'h0200;
    localparam logic [15:0] DEV2_ADDR_BASE = 16'h0300;
    localparam logic [15:0] DEV3_ADDR_BASE = 16'h0400;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_QUIESCE,
        ST_APPLY,
        ST_RELEASE
    } commit_state_e;

endpackage

// File: rtl/conf_commit_fsm.sv
// Commit handshake: quiesce the device, wait (bounded) for dev_idle,
// pulse apply for one cycle, then release.
module conf_commit_fsm
    import conf_dev_regs_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic commit,
    input  logic dev_idle,
    output logic dev_quiesce,
    output logic apply,
    output logic timeout,
    output logic busy
);
    localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

    commit_state_e state_q, state_d;
    logic [9:0]    cnt_q, cnt_d;
    logic          quiesce_q, quiesce_d;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            quiesce_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quiesce_q <= quiesce_d;
        end
    end

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quiesce_d = quiesce_q;
        apply     = 1'b0;
        timeout   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (commit) begin
                    state_d   = ST_QUIESCE;
                    cnt_d     = '0;
                    quiesce_d = 1'b1;
                end
            end
            ST_QUIESCE: begin
                if (dev_idle) begin
                    state_d = ST_APPLY;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    timeout = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            ST_APPLY: begin
                apply   = 1'b1;
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                quiesce_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dev_quiesce = quiesce_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: rtl/conf_dev_regs.sv
// Per-device configuration bank: shadow registers, atomic commit into active outputs.
// Define CONF_DEV_REGS_LOCK_EN to add the KEY register and write lock.
module conf_dev_regs
    import conf_dev_regs_pkg::*;
#(
    parameter logic [15:0] ADDR_BASE = DEV0_ADDR_BASE,
    parameter int unsigned NCFG      = 4,
    parameter logic [15:0] DEV_ID    = 16'h0000,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          conf_addr,
    input  logic                 conf_write,
    input  logic [15:0]          conf_wdata,
    output logic                 conf_match,
    output logic [15:0]          conf_rdata,
    output logic                 dev_quiesce,
    input  logic                 dev_idle,
    output logic [16*NCFG-1:0]   active_cfg,
    output logic                 cfg_applied
);
    localparam logic [15:0] CFG_END = CDR_CFG0 + 16'(NCFG);

    logic [15:0] offset;
    logic [15:0] shadow_q [NCFG];
    logic [15:0] shadow_d [NCFG];
    logic [15:0] active_q [NCFG];
    logic [15:0] active_d [NCFG];
    logic        err_q, err_d, ovr_q, ovr_d;
    logic        cfg_applied_q, cfg_applied_d;
    logic        locked, busy, apply, timeout, pending;
    logic        wr, wr_ctrl, wr_cfg, ctrl_ok, commit, revert;

    assign offset = conf_addr - ADDR_BASE;

    always_comb begin
        conf_match = 1'b0;
        if (offset < CFG_END) begin
`ifdef CONF_DEV_REGS_LOCK_EN
            conf_match = 1'b1;
`else
            conf_match = (offset != CDR_KEY);
`endif
        end
    end

    always_comb begin
        wr      = conf_write && conf_match;
        wr_ctrl = wr && (offset == CDR_CTRL);
        wr_cfg  = wr && (offset >= CDR_CFG0);
        ctrl_ok = wr_ctrl && !locked && !busy;
        commit  = ctrl_ok && conf_wdata[CTRL_COMMIT];
        revert  = ctrl_ok && conf_wdata[CTRL_REVERT] && !conf_wdata[CTRL_COMMIT];
    end

`ifdef CONF_DEV_REGS_LOCK_EN
    logic locked_q, locked_d;

    // A successful apply relocks; a timeout leaves the lock as it was.
    always_comb begin
        locked_d = locked_q;
        if (apply) begin
            locked_d = 1'b1;
        end else if (wr && (offset == CDR_KEY)) begin
            locked_d = (conf_wdata != UNLOCK_KEY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q <= 1'b1;
        end else begin
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;
`else
    assign locked = 1'b0;
`endif

    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < int'(NCFG); i++) begin
            if (shadow_q[i] != active_q[i]) pending = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NCFG); i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = active_q[i];
            if (revert) begin
                shadow_d[i] = active_q[i];
            end else if (wr_cfg && !locked && !busy && (offset == CDR_CFG0 + 16'(i))) begin
                shadow_d[i] = conf_wdata;
            end
            if (apply) active_d[i] = shadow_q[i];
        end
        err_d = err_q;
        ovr_d = ovr_q;
        if (wr_ctrl && conf_wdata[CTRL_CLRERR]) begin
            err_d = 1'b0;
            ovr_d = 1'b0;
        end
        if (timeout) err_d = 1'b1;
        if (busy && !locked &&
            ((wr_ctrl && (conf_wdata[CTRL_COMMIT] || conf_wdata[CTRL_REVERT])) || wr_cfg)) begin
            ovr_d = 1'b1;
        end
        cfg_applied_d = apply;
    end

    // NOTE: the register bank is small flop storage that must read as zero
    // after reset, so every entry is reset explicitly.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NCFG); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            err_q         <= 1'b0;
            ovr_q         <= 1'b0;
            cfg_applied_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            err_q         <= err_d;
            ovr_q         <= ovr_d;
            cfg_applied_q <= cfg_applied_d;
        end
    end

    always_comb begin
        conf_rdata = '0;
        if (conf_match) begin
            if (offset == CDR_ID) begin
                conf_rdata = DEV_ID;
            end else if (offset == CDR_CTRL) begin
                conf_rdata = {busy, pending, locked, err_q, ovr_q, 11'b0};
            end else begin
                for (int i = 0; i < int'(NCFG); i++) begin
                    if (offset == CDR_CFG0 + 16'(i)) conf_rdata = shadow_q[i];
                end
            end
        end
    end

    always_comb begin
        active_cfg = '0;
        for (int i = 0; i < int'(NCFG); i++) begin
            active_cfg[16*i +: 16] = active_q[i];
        end
    end

    assign cfg_applied = cfg_applied_q;

    conf_commit_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_commit_fsm (
        .clk         (clk),
        .reset       (reset),
        .commit      (commit),
        .dev_idle    (dev_idle),
        .dev_quiesce (dev_quiesce),
        .apply       (apply),
        .timeout     (timeout),
        .busy        (busy)
    );

endmodule
